// File: rtl/mig_write_coalescer.sv
// Packs rasterizer pixel writes into MIG-width words with byte strobes.
// Emits one request per word through a single-entry output register.
module mig_write_coalescer #(
    parameter int HRES       = 320,
    parameter int VRES       = 180,
    parameter int PIXEL_W    = 16,
    parameter int WORD_W     = 128,
    parameter int ADDR_W     = 27,
    parameter int IDLE_FLUSH = 16
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic [$clog2(HRES)-1:0] hcount,
    input  logic [$clog2(VRES)-1:0] vcount,
    input  logic [PIXEL_W-1:0]      color,
    input  logic                    mask_in,
    input  logic                    frame,
    input  logic                    flush_in,
    input  logic                    valid_in,
    output logic                    rdy_out,
    output logic [ADDR_W-1:0]       addr_out,
    output logic [WORD_W-1:0]       data_out,
    output logic [WORD_W/8-1:0]     strobe_out,
    output logic                    valid_out,
    input  logic                    rdy_in,
    output logic                    dropped_out,
    output logic                    busy_out
);
    localparam int PPW    = WORD_W / PIXEL_W;
    localparam int STRB_W = WORD_W / 8;
    localparam int BPP    = PIXEL_W / 8;
    localparam int LANE_W = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int PIX_W  = ADDR_W + LANE_W;
    localparam int IDLE_W = (IDLE_FLUSH > 0) ? $clog2(IDLE_FLUSH + 1) : 1;

    typedef enum logic {EMPTY, ACC} state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   acc_addr_reg, acc_addr_next;
    logic [WORD_W-1:0]   acc_data_reg, acc_data_next;
    logic [STRB_W-1:0]   acc_strb_reg, acc_strb_next;
    logic                pend_reg, pend_next;
    logic [IDLE_W-1:0]   idle_cnt_reg, idle_cnt_next;
    logic                valid_reg, valid_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [WORD_W-1:0]   data_reg, data_next;
    logic [STRB_W-1:0]   strb_reg, strb_next;
    logic                dropped_reg, dropped_next;

    logic                accept, in_range, pix, lane_last, idle_hit, emit;
    logic [PIX_W-1:0]    pix_index;
    logic [ADDR_W-1:0]   pix_word;
    logic [LANE_W-1:0]   pix_lane;
    logic [PPW-1:0]      lane_hit;
    logic [WORD_W-1:0]   fresh_data, merge_data, emit_data;
    logic [STRB_W-1:0]   fresh_strb, merge_strb, emit_strb;
    logic [ADDR_W-1:0]   emit_addr;

    assign rdy_out     = !valid_reg || rdy_in;
    assign valid_out   = valid_reg;
    assign addr_out    = addr_reg;
    assign data_out    = data_reg;
    assign strobe_out  = strb_reg;
    assign dropped_out = dropped_reg;
    assign busy_out    = (state_reg == ACC) || valid_reg;

    assign accept   = valid_in && rdy_out;
    assign in_range = (32'(hcount) < HRES) && (32'(vcount) < VRES);
    assign pix      = accept && in_range;

    // Linear pixel index; PPW is a power of two, so word/lane are a bit split.
    assign pix_index = PIX_W'(hcount) + PIX_W'(vcount) * PIX_W'(HRES)
                     + (frame ? PIX_W'(HRES * VRES) : PIX_W'(0));
    assign pix_word  = pix_index[PIX_W-1:LANE_W];
    assign pix_lane  = pix_index[LANE_W-1:0];
    assign lane_last = (pix_lane == LANE_W'(PPW - 1));
    assign idle_hit  = (IDLE_FLUSH != 0) && (idle_cnt_reg >= IDLE_W'(IDLE_FLUSH));

    genvar gi;
    generate
        for (gi = 0; gi < PPW; gi++) begin : g_lane
            assign lane_hit[gi] = (pix_lane == LANE_W'(gi));
            assign fresh_data[gi*PIXEL_W +: PIXEL_W] = lane_hit[gi] ? color : '0;
            assign merge_data[gi*PIXEL_W +: PIXEL_W] =
                lane_hit[gi] ? color : acc_data_reg[gi*PIXEL_W +: PIXEL_W];
            assign fresh_strb[gi*BPP +: BPP] = {BPP{lane_hit[gi] && mask_in}};
        end
    endgenerate

    assign merge_strb = acc_strb_reg | fresh_strb;

    always_comb begin
        state_next    = state_reg;
        acc_addr_next = acc_addr_reg;
        acc_data_next = acc_data_reg;
        acc_strb_next = acc_strb_reg;
        pend_next     = pend_reg;
        emit          = 1'b0;
        emit_addr     = acc_addr_reg;
        emit_data     = acc_data_reg;
        emit_strb     = acc_strb_reg;
        if (rdy_out) begin
            if (state_reg == EMPTY) begin
                if (pix) begin
                    if (lane_last || flush_in) begin
                        emit      = 1'b1;
                        emit_addr = pix_word;
                        emit_data = fresh_data;
                        emit_strb = fresh_strb;
                    end else begin
                        state_next    = ACC;
                        acc_addr_next = pix_word;
                        acc_data_next = fresh_data;
                        acc_strb_next = fresh_strb;
                        pend_next     = 1'b0;
                    end
                end
            end else if (pix && (pix_word != acc_addr_reg)) begin
                // Output slot taken by the old word; a completed new word waits a cycle.
                emit          = 1'b1;
                acc_addr_next = pix_word;
                acc_data_next = fresh_data;
                acc_strb_next = fresh_strb;
                pend_next     = lane_last;
            end else if (pix) begin
                if (lane_last || flush_in || pend_reg) begin
                    emit       = 1'b1;
                    emit_data  = merge_data;
                    emit_strb  = merge_strb;
                    state_next = EMPTY;
                    pend_next  = 1'b0;
                end else begin
                    acc_data_next = merge_data;
                    acc_strb_next = merge_strb;
                end
            end else if (flush_in || pend_reg || idle_hit) begin
                emit       = 1'b1;
                state_next = EMPTY;
                pend_next  = 1'b0;
            end
        end
    end

    always_comb begin
        idle_cnt_next = idle_cnt_reg;
        if (accept || state_next == EMPTY || IDLE_FLUSH == 0)
            idle_cnt_next = '0;
        else if (!idle_hit)
            idle_cnt_next = idle_cnt_reg + 1'b1;
    end

    always_comb begin
        valid_next   = valid_reg;
        addr_next    = addr_reg;
        data_next    = data_reg;
        strb_next    = strb_reg;
        dropped_next = accept && !in_range;
        if (rdy_out) begin
            // A word with no enabled byte is silently discarded.
            valid_next = emit && (|emit_strb);
            if (emit && (|emit_strb)) begin
                addr_next = emit_addr;
                data_next = emit_data;
                strb_next = emit_strb;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_reg    <= EMPTY;
            acc_addr_reg <= '0;
            acc_data_reg <= '0;
            acc_strb_reg <= '0;
            pend_reg     <= 1'b0;
            idle_cnt_reg <= '0;
            valid_reg    <= 1'b0;
            addr_reg     <= '0;
            data_reg     <= '0;
            strb_reg     <= '0;
            dropped_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            acc_addr_reg <= acc_addr_next;
            acc_data_reg <= acc_data_next;
            acc_strb_reg <= acc_strb_next;
            pend_reg     <= pend_next;
            idle_cnt_reg <= idle_cnt_next;
            valid_reg    <= valid_next;
            addr_reg     <= addr_next;
            data_reg     <= data_next;
            strb_reg     <= strb_next;
            dropped_reg  <= dropped_next;
        end
    end
endmodule

// File: tb/tb_mig_write_coalescer.sv
// Scoreboard bench for mig_write_coalescer: directed pixel streams push expected
// requests, an independent monitor pops and compares every accepted output.
module tb_mig_write_coalescer;
    logic         clk_in = 1'b0;
    logic         rst_in = 1'b0;
    logic [8:0]   hcount = '0;
    logic [7:0]   vcount = '0;
    logic [15:0]  color = '0;
    logic         mask_in = 1'b0;
    logic         frame = 1'b0;
    logic         flush_in = 1'b0;
    logic         valid_in = 1'b0;
    logic         rdy_out;
    logic [26:0]  addr_out;
    logic [127:0] data_out;
    logic [15:0]  strobe_out;
    logic         valid_out;
    logic         rdy_in = 1'b1;
    logic         dropped_out;
    logic         busy_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [26:0]  addr;
        logic [127:0] data;
        logic [15:0]  strb;
    } req_t;
    req_t sb[$];

    mig_write_coalescer dut (
        .clk_in(clk_in), .rst_in(rst_in), .hcount(hcount), .vcount(vcount),
        .color(color), .mask_in(mask_in), .frame(frame), .flush_in(flush_in),
        .valid_in(valid_in), .rdy_out(rdy_out), .addr_out(addr_out),
        .data_out(data_out), .strobe_out(strobe_out), .valid_out(valid_out),
        .rdy_in(rdy_in), .dropped_out(dropped_out), .busy_out(busy_out)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [127:0] byte_mask(input logic [15:0] s);
        logic [127:0] m;
        m = '0;
        for (int b = 0; b < 16; b++) m[b*8 +: 8] = {8{s[b]}};
        return m;
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    task automatic push_req(input logic [26:0] a, input logic [15:0] s, input logic [127:0] d);
        req_t r;
        r.addr = a; r.strb = s; r.data = d;
        sb.push_back(r);
    endtask

    // Monitor: a request transfers on the next posedge when valid_out && rdy_in.
    always @(negedge clk_in) begin
        if (rst_in && valid_out && rdy_in) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_req: got addr=%0d strb=%h, required no request", addr_out, strobe_out);
            end else begin
                req_t r;
                r = sb.pop_front();
                $display("req addr=%0d strb=%h data=%h", addr_out, strobe_out, data_out);
                check("req_addr", 128'(addr_out), 128'(r.addr));
                check("req_strb", 128'(strobe_out), 128'(r.strb));
                check("req_data", data_out & byte_mask(r.strb), r.data & byte_mask(r.strb));
            end
        end
    end

    task automatic send_pix(input int h, input int v, input logic [15:0] c,
                            input logic m, input logic f, input logic fl);
        int guard;
        hcount = 9'(h); vcount = 8'(v); color = c; mask_in = m; frame = f;
        flush_in = fl; valid_in = 1'b1;
        guard = 0;
        while (!rdy_out && guard < 200) begin
            @(posedge clk_in); #1; guard++;
        end
        if (!rdy_out) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got rdy_out=0, required 1 within 200 cycles");
        end
        @(posedge clk_in); #1;
        valid_in = 1'b0; flush_in = 1'b0;
    endtask

    task automatic do_flush();
        int guard;
        flush_in = 1'b1; valid_in = 1'b0;
        guard = 0;
        while (!rdy_out && guard < 200) begin
            @(posedge clk_in); #1; guard++;
        end
        @(posedge clk_in); #1;
        flush_in = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((busy_out || valid_out || sb.size() != 0) && guard < 100) begin
            @(posedge clk_in); #1; guard++;
        end
        if (busy_out || valid_out || sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL idle_timeout: got busy=%0b pending=%0d, required idle", busy_out, sb.size());
        end
    endtask

    initial begin
        logic [127:0] wd;

        repeat (3) @(posedge clk_in);
        #1;
        check("rst_valid", 128'(valid_out), 128'(0));
        check("rst_busy", 128'(busy_out), 128'(0));
        check("rst_dropped", 128'(dropped_out), 128'(0));
        check("rst_addr", 128'(addr_out), 128'(0));
        check("rst_strb", 128'(strobe_out), 128'(0));
        rst_in = 1'b1;
        @(posedge clk_in); #1;

        // Full word, lanes 0..7 of row 0.
        wd = '0;
        for (int h = 0; h < 8; h++) wd[h*16 +: 16] = 16'hA000 + 16'(h);
        push_req(27'd0, 16'hFFFF, wd);
        for (int h = 0; h < 8; h++) send_pix(h, 0, 16'hA000 + 16'(h), 1'b1, 1'b0, 1'b0);
        wait_idle();

        // Word change flushes partial word 0; explicit flush emits word 5.
        wd = '0;
        for (int h = 0; h < 3; h++) wd[h*16 +: 16] = 16'hB000 + 16'(h);
        push_req(27'd0, 16'h003F, wd);
        push_req(27'd5, 16'h0003, {112'd0, 16'hB040});
        for (int h = 0; h < 3; h++) send_pix(h, 0, 16'hB000 + 16'(h), 1'b1, 1'b0, 1'b0);
        send_pix(40, 0, 16'hB040, 1'b1, 1'b0, 1'b0);
        do_flush();
        wait_idle();

        // Back buffer with downstream stalled: output must hold.
        wd = '0;
        for (int h = 0; h < 8; h++) wd[h*16 +: 16] = 16'hE100 + 16'(h);
        push_req(27'd7200, 16'hFFFF, wd);
        rdy_in = 1'b0;
        for (int h = 0; h < 8; h++) send_pix(h, 0, 16'hE100 + 16'(h), 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("stall_valid", 128'(valid_out), 128'(1));
            check("stall_rdy_out", 128'(rdy_out), 128'(0));
            check("stall_addr", 128'(addr_out), 128'(27'd7200));
            check("stall_data", data_out, wd);
            @(posedge clk_in); #1;
        end
        rdy_in = 1'b1;
        wait_idle();

        // Mask 1,0,1,0 then word change; then an all-masked word yields nothing.
        wd = '0;
        wd[15:0] = 16'hC000;
        wd[47:32] = 16'hC002;
        push_req(27'd0, 16'h0033, wd);
        for (int h = 0; h < 4; h++) send_pix(h, 0, 16'hC000 + 16'(h), ~1'(h), 1'b0, 1'b0);
        for (int h = 8; h < 16; h++) send_pix(h, 0, 16'hC000 + 16'(h), 1'b0, 1'b0, 1'b0);
        wait_idle();

        // Idle timeout flushes a partial word.
        wd = '0;
        for (int h = 0; h < 3; h++) wd[h*16 +: 16] = 16'hD010 + 16'(h);
        push_req(27'd2, 16'h003F, wd);
        for (int h = 16; h < 19; h++) send_pix(h, 0, 16'hD000 + 16'(h), 1'b1, 1'b0, 1'b0);
        check("idle_busy", 128'(busy_out), 128'(1));
        wait_idle();

        // Out-of-range pixels are dropped with a one-cycle pulse.
        send_pix(320, 0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        check("drop_h_pulse", 128'(dropped_out), 128'(1));
        check("drop_h_state", 128'(busy_out), 128'(0));
        @(posedge clk_in); #1;
        check("drop_h_clear", 128'(dropped_out), 128'(0));
        send_pix(0, 180, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        check("drop_v_pulse", 128'(dropped_out), 128'(1));
        @(posedge clk_in); #1;
        check("drop_v_clear", 128'(dropped_out), 128'(0));
        wait_idle();

        // Reset while a request is held and the accumulator is occupied.
        send_pix(0, 1, 16'hF000, 1'b1, 1'b0, 1'b0);
        send_pix(1, 1, 16'hF001, 1'b1, 1'b0, 1'b0);
        rdy_in = 1'b0;
        send_pix(8, 1, 16'hF008, 1'b1, 1'b0, 1'b0);
        check("pre_rst_valid", 128'(valid_out), 128'(1));
        check("pre_rst_busy", 128'(busy_out), 128'(1));
        rst_in = 1'b0;
        @(posedge clk_in); #1;
        check("mid_rst_valid", 128'(valid_out), 128'(0));
        check("mid_rst_busy", 128'(busy_out), 128'(0));
        rst_in = 1'b1;
        rdy_in = 1'b1;
        repeat (40) @(posedge clk_in);
        #1;
        check("post_rst_busy", 128'(busy_out), 128'(0));
        check("sb_empty", 128'(sb.size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
